// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter sharing the register file write port between the ALU
// and load writeback paths, with a pending-write scoreboard for decode stalls.
module reg_write_arbiter #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 64,
    parameter int NUM_REGS   = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  alu_wr_valid,
    input  logic [ADDR_WIDTH-1:0] alu_wr_addr,
    input  logic [DATA_WIDTH-1:0] alu_wr_data,
    output logic                  alu_wr_ready,
    input  logic                  mem_wr_valid,
    input  logic [ADDR_WIDTH-1:0] mem_wr_addr,
    input  logic [DATA_WIDTH-1:0] mem_wr_data,
    output logic                  mem_wr_ready,
    input  logic                  issue_valid,
    input  logic [ADDR_WIDTH-1:0] issue_addr,
    output logic                  RegWrite,
    output logic [ADDR_WIDTH-1:0] write_reg_addr,
    output logic [DATA_WIDTH-1:0] write_reg_data,
    output logic [NUM_REGS-1:0]   busy_vec,
    output logic                  last_grant
);

    localparam logic GRANT_ALU = 1'b0;
    localparam logic GRANT_MEM = 1'b1;

    logic                  r_reg_write;
    logic [ADDR_WIDTH-1:0] r_wr_addr;
    logic [DATA_WIDTH-1:0] r_wr_data;
    logic [NUM_REGS-1:0]   r_busy;
    logic                  r_last_grant;

    logic                  w_alu_rdy;
    logic                  w_mem_rdy;
    logic                  w_acc;
    logic [ADDR_WIDTH-1:0] w_acc_addr;
    logic [DATA_WIDTH-1:0] w_acc_data;
    logic                  w_acc_nonzero;
    logic                  w_issue_set;

    // Clear of a retiring write is applied first so that a same-index issue
    // in the same cycle leaves the bit set for the newer instruction.
    function automatic logic [NUM_REGS-1:0] next_busy(
        input logic [NUM_REGS-1:0]   cur,
        input logic                  clr_en,
        input logic [ADDR_WIDTH-1:0] clr_addr,
        input logic                  set_en,
        input logic [ADDR_WIDTH-1:0] set_addr
    );
        logic [NUM_REGS-1:0] nxt;
        nxt = cur;
        if (clr_en) nxt[clr_addr] = 1'b0;
        if (set_en) nxt[set_addr] = 1'b1;
        nxt[0] = 1'b0;
        return nxt;
    endfunction

    // On conflict the requester opposite the last grant wins.
    always_comb begin
        w_alu_rdy = 1'b0;
        w_mem_rdy = 1'b0;
        if (!reset) begin
            if (alu_wr_valid && mem_wr_valid) begin
                w_alu_rdy = (r_last_grant == GRANT_MEM);
                w_mem_rdy = (r_last_grant == GRANT_ALU);
            end else begin
                w_alu_rdy = alu_wr_valid;
                w_mem_rdy = mem_wr_valid;
            end
        end
    end

    always_comb begin
        w_acc      = 1'b0;
        w_acc_addr = r_wr_addr;
        w_acc_data = r_wr_data;
        if (w_alu_rdy) begin
            w_acc      = 1'b1;
            w_acc_addr = alu_wr_addr;
            w_acc_data = alu_wr_data;
        end else if (w_mem_rdy) begin
            w_acc      = 1'b1;
            w_acc_addr = mem_wr_addr;
            w_acc_data = mem_wr_data;
        end
    end

    assign w_acc_nonzero = w_acc && (w_acc_addr != '0);
    assign w_issue_set   = issue_valid && (issue_addr != '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_reg_write  <= 1'b0;
            r_wr_addr    <= '0;
            r_wr_data    <= '0;
            r_busy       <= '0;
            r_last_grant <= GRANT_MEM;
        end else begin
            r_reg_write <= w_acc_nonzero;
            if (w_acc) begin
                r_wr_addr    <= w_acc_addr;
                r_wr_data    <= w_acc_data;
                r_last_grant <= w_alu_rdy ? GRANT_ALU : GRANT_MEM;
            end
            r_busy <= next_busy(r_busy, w_acc_nonzero, w_acc_addr,
                                w_issue_set, issue_addr);
        end
    end

    assign alu_wr_ready   = w_alu_rdy;
    assign mem_wr_ready   = w_mem_rdy;
    assign RegWrite       = r_reg_write;
    assign write_reg_addr = r_wr_addr;
    assign write_reg_data = r_wr_data;
    assign busy_vec       = r_busy;
    assign last_grant     = r_last_grant;

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Scoreboard bench for reg_write_arbiter: expected writes are queued at
// accept time and compared against the register-file outputs one cycle later.
module tb_reg_write_arbiter;

    localparam int AW = 5;
    localparam int DW = 64;
    localparam int NR = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          alu_wr_valid, mem_wr_valid, issue_valid;
    logic [AW-1:0] alu_wr_addr, mem_wr_addr, issue_addr;
    logic [DW-1:0] alu_wr_data, mem_wr_data;
    logic          alu_wr_ready, mem_wr_ready;
    logic          RegWrite;
    logic [AW-1:0] write_reg_addr;
    logic [DW-1:0] write_reg_data;
    logic [NR-1:0] busy_vec;
    logic          last_grant;

    reg_write_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REGS(NR)) dut (
        .clk(clk), .reset(reset),
        .alu_wr_valid(alu_wr_valid), .alu_wr_addr(alu_wr_addr),
        .alu_wr_data(alu_wr_data), .alu_wr_ready(alu_wr_ready),
        .mem_wr_valid(mem_wr_valid), .mem_wr_addr(mem_wr_addr),
        .mem_wr_data(mem_wr_data), .mem_wr_ready(mem_wr_ready),
        .issue_valid(issue_valid), .issue_addr(issue_addr),
        .RegWrite(RegWrite), .write_reg_addr(write_reg_addr),
        .write_reg_data(write_reg_data), .busy_vec(busy_vec),
        .last_grant(last_grant)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    wr_t           exp_q[$];
    int            n_checks = 0;
    int            n_fail   = 0;

    logic          m_lg;
    logic [NR-1:0] m_busy;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_data;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic cycle(input logic rst,
                         input logic av, input logic [AW-1:0] aa, input logic [DW-1:0] ad,
                         input logic mv, input logic [AW-1:0] ma, input logic [DW-1:0] md,
                         input logic iv, input logic [AW-1:0] ia);
        logic ea, em;
        wr_t  w;
        @(negedge clk);
        reset = rst;
        alu_wr_valid = av; alu_wr_addr = aa; alu_wr_data = ad;
        mem_wr_valid = mv; mem_wr_addr = ma; mem_wr_data = md;
        issue_valid = iv;  issue_addr = ia;
        #1;
        ea = 1'b0; em = 1'b0;
        if (!rst) begin
            if (av && mv) begin
                ea = (m_lg == 1'b1);
                em = (m_lg == 1'b0);
            end else begin
                ea = av;
                em = mv;
            end
        end
        check_eq("alu_ready", alu_wr_ready, ea);
        check_eq("mem_ready", mem_wr_ready, em);

        if (rst) begin
            exp_q.delete();
            m_lg = 1'b1; m_busy = '0; m_addr = '0; m_data = '0;
        end else begin
            if (ea || em) begin
                w.addr = ea ? aa : ma;
                w.data = ea ? ad : md;
                w.we   = (w.addr != 0);
                exp_q.push_back(w);
                m_lg   = em;
                m_addr = w.addr;
                m_data = w.data;
                if (w.addr != 0) m_busy[w.addr] = 1'b0;
            end
            if (iv && ia != 0) m_busy[ia] = 1'b1;
        end

        @(posedge clk);
        #1;
        if (exp_q.size() > 0) begin
            w = exp_q.pop_front();
            check_eq("regwrite", RegWrite, w.we);
            check_eq("wr_addr", write_reg_addr, w.addr);
            check_eq("wr_data", write_reg_data, w.data);
        end else begin
            check_eq("regwrite_idle", RegWrite, 1'b0);
            check_eq("wr_addr_hold", write_reg_addr, m_addr);
            check_eq("wr_data_hold", write_reg_data, m_data);
        end
        check_eq("busy_vec", busy_vec, m_busy);
        check_eq("last_grant", last_grant, m_lg);
    endtask

    task automatic idle();
        cycle(1'b0, 1'b0, '0, '0, 1'b0, '0, '0, 1'b0, '0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

    initial begin
        m_lg = 1'b1; m_busy = '0; m_addr = '0; m_data = '0;
        reset = 1'b1;
        alu_wr_valid = 0; alu_wr_addr = '0; alu_wr_data = '0;
        mem_wr_valid = 0; mem_wr_addr = '0; mem_wr_data = '0;
        issue_valid = 0;  issue_addr = '0;

        // Reset for two cycles, then idle
        cycle(1'b1, 0, '0, '0, 0, '0, '0, 0, '0);
        cycle(1'b1, 0, '0, '0, 0, '0, '0, 0, '0);
        idle();

        // Single ALU write
        cycle(1'b0, 1, 5'd5, 64'h1234, 0, '0, '0, 0, '0);
        idle();

        // Conflict, round-robin over two cycles
        cycle(1'b0, 1, 5'd3, 64'hA, 1, 5'd7, 64'hB, 0, '0);
        cycle(1'b0, 1, 5'd3, 64'hA, 1, 5'd7, 64'hB, 0, '0);
        idle();

        // Write to x0 is accepted but dropped
        cycle(1'b0, 0, '0, '0, 1, 5'd0, 64'hFF, 0, '0);
        idle();

        // Scoreboard set / same-index set+clear / clear
        cycle(1'b0, 0, '0, '0, 0, '0, '0, 1, 5'd9);
        idle();
        cycle(1'b0, 1, 5'd9, 64'h99, 0, '0, '0, 1, 5'd9);
        check_eq("busy9_set_wins", busy_vec[9], 1'b1);
        cycle(1'b0, 1, 5'd9, 64'h9A, 0, '0, '0, 0, '0);
        check_eq("busy9_cleared", busy_vec[9], 1'b0);
        // Different indices set and cleared together, and issue to x0
        cycle(1'b0, 0, '0, '0, 0, '0, '0, 1, 5'd12);
        cycle(1'b0, 0, '0, '0, 1, 5'd12, 64'h12, 1, 5'd20);
        cycle(1'b0, 0, '0, '0, 0, '0, '0, 1, 5'd0);

        // Reset in the cycle MEM would win, then ALU wins after release
        cycle(1'b0, 1, 5'd4, 64'h44, 1, 5'd6, 64'h66, 1, 5'd15);
        cycle(1'b1, 1, 5'd4, 64'h45, 1, 5'd6, 64'h66, 0, '0);
        cycle(1'b0, 1, 5'd8, 64'h88, 1, 5'd6, 64'h66, 0, '0);
        idle();

        // Random traffic
        for (int i = 0; i < 200; i++) begin
            cycle(($urandom_range(0, 49) == 0),
                  $urandom_range(0, 1), AW'($urandom), {$urandom, $urandom},
                  $urandom_range(0, 1), AW'($urandom), {$urandom, $urandom},
                  $urandom_range(0, 1), AW'($urandom));
        end
        idle();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
